// File: rtl/quat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : quat_pkg                                                        |
// | Purpose  : Shared widths, divider length, FSM state enumeration and the    |
// |            term-selection helpers for the sequential quaternion divider.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package quat_pkg;

  localparam int IN_W       = 16;
  localparam int PROD_W     = 32;
  localparam int ACC_W      = 50;
  localparam int NORM_W     = 33;
  localparam int DIV_CYCLES = 50;
  localparam int MUL_W      = IN_W + PROD_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_MAC   = 3'd2,
    S_DIV   = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Sign of term j within numerator k, one nibble per k (bit j = subtract).
  // k0: ++++, k1: +--+, k2: ++--, k3: +-+-
  localparam logic [15:0] C_NEG_MAP = 16'b1010_1100_0110_0000;

  function automatic logic term_neg(input logic [1:0] k, input logic [1:0] j);
    return C_NEG_MAP[{k, j}];
  endfunction

  // Numerator k pairs a_j with q_(j xor k) in every one of its four terms.
  function automatic logic [1:0] q_sel(input logic [1:0] k, input logic [1:0] j);
    return j ^ k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_restoring_divider                                           |
// | Purpose  : Unsigned ACC_W / NORM_W restoring divider, one quotient bit per |
// |            clock. The edge that samples start also performs the first     |
// |            iteration, so the quotient is complete DIV_CYCLES edges after  |
// |            (and including) the start edge; done pulses with the last bit. |
// | Ports    : clk, rst_n (async, active low), start, dividend, divisor,       |
// |            quotient (valid while idle after done), done (1-cycle pulse).   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_restoring_divider
  import quat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ACC_W-1:0]  dividend,
  input  logic [NORM_W-1:0] divisor,
  output logic [ACC_W-1:0]  quotient,
  output logic              done
);

  logic [NORM_W-1:0] r_rem;
  logic [NORM_W-1:0] r_dvs;
  logic [ACC_W-1:0]  r_dvd;   // shifts dividend out, quotient in
  logic [5:0]        r_cnt;
  logic              r_active;
  logic              r_done;

  logic [NORM_W-1:0] w_rem_cur;
  logic [ACC_W-1:0]  w_dvd_cur;
  logic [NORM_W-1:0] w_dvs_cur;
  logic [NORM_W:0]   w_shift;
  logic [NORM_W:0]   w_sub;
  logic              w_qbit;
  logic [NORM_W-1:0] w_rem_nxt;
  logic [ACC_W-1:0]  w_dvd_nxt;

  always_comb begin
    w_rem_cur = start ? '0       : r_rem;
    w_dvd_cur = start ? dividend : r_dvd;
    w_dvs_cur = start ? divisor  : r_dvs;
    w_shift   = {w_rem_cur, w_dvd_cur[ACC_W-1]};
    w_qbit    = (w_shift >= {1'b0, w_dvs_cur});
    w_sub     = w_shift - {1'b0, w_dvs_cur};
    // The kept remainder is always below the divisor, so it fits NORM_W bits.
    w_rem_nxt = w_qbit ? NORM_W'(w_sub) : NORM_W'(w_shift);
    w_dvd_nxt = {w_dvd_cur[ACC_W-2:0], w_qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_dvs    <= '0;
      r_dvd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_dvs    <= divisor;
        r_rem    <= w_rem_nxt;
        r_dvd    <= w_dvd_nxt;
        r_cnt    <= 6'(DIV_CYCLES - 1);
        r_active <= 1'b1;
      end else if (r_active) begin
        r_rem <= w_rem_nxt;
        r_dvd <= w_dvd_nxt;
        r_cnt <= r_cnt - 6'd1;
        if (r_cnt == 6'd1) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = r_dvd;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: rtl/quaternion_division_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quaternion_division_seq                                         |
// | Purpose  : Recovers b from q = a (x) b as b = conj(a) (x) q / |a|^2 using   |
// |            one shared 16x32 multiplier and a serial restoring divider.    |
// |            Sequence: NORM(4) -> 4 x {MAC(4), DIV(50), WRITE(1)} -> FIN(1).  |
// | Ports    : clk, rst_n (async, active low), start,                         |
// |            a0..a3 (s16), q0..q3 (s32)  -> b0..b3 (s16, saturated),        |
// |            busy, done (1-cycle pulse), div_by_zero, ovf.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module quaternion_division_seq
  import quat_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [IN_W-1:0]   a0,
  input  logic signed [IN_W-1:0]   a1,
  input  logic signed [IN_W-1:0]   a2,
  input  logic signed [IN_W-1:0]   a3,
  input  logic signed [PROD_W-1:0] q0,
  input  logic signed [PROD_W-1:0] q1,
  input  logic signed [PROD_W-1:0] q2,
  input  logic signed [PROD_W-1:0] q3,
  output logic signed [IN_W-1:0]   b0,
  output logic signed [IN_W-1:0]   b1,
  output logic signed [IN_W-1:0]   b2,
  output logic signed [IN_W-1:0]   b3,
  output logic                     busy,
  output logic                     done,
  output logic                     div_by_zero,
  output logic                     ovf
);

  state_t                   r_state;
  logic [5:0]               r_cnt;     // term index in NORM/MAC, cycle count in DIV
  logic [1:0]               r_k;       // component being produced
  logic signed [IN_W-1:0]   r_a [4];
  logic signed [PROD_W-1:0] r_q [4];
  logic [NORM_W-1:0]        r_norm;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [IN_W-1:0]   r_b [4];
  logic                     r_busy;
  logic                     r_done;
  logic                     r_dbz;
  logic                     r_ovf;

  logic [1:0]               w_j;
  logic signed [IN_W-1:0]   w_mx;
  logic signed [PROD_W-1:0] w_my;
  logic signed [MUL_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [NORM_W-1:0]        w_norm_nxt;
  logic                     w_p_neg;
  logic [ACC_W-1:0]         w_p_mag;
  logic                     w_div_start;
  logic [ACC_W-1:0]         w_quot;
  logic                     w_div_done;
  logic                     w_sat_ovf;
  logic signed [IN_W-1:0]   w_sat_val;

  // Shared multiplier: squares a_j during NORM, a_j * q_(j^k) during MAC.
  always_comb begin
    w_j  = r_cnt[1:0];
    w_mx = r_a[w_j];
    if (r_state == S_MAC) begin
      w_my = r_q[q_sel(r_k, w_j)];
    end else begin
      w_my = PROD_W'(r_a[w_j]);
    end
    w_prod     = MUL_W'(w_mx) * MUL_W'(w_my);
    w_prod_ext = ACC_W'(w_prod);
    w_term     = term_neg(r_k, w_j) ? -w_prod_ext : w_prod_ext;
    w_acc_nxt  = ((r_cnt == 6'd0) ? '0 : r_acc) + w_term;
    // Squares are non-negative and below 2^31, so the low word is exact.
    w_norm_nxt = r_norm + NORM_W'(w_prod[PROD_W-1:0]);
  end

  // Divide magnitudes; the sign of p is reapplied after the quotient returns.
  always_comb begin
    w_p_neg     = r_acc[ACC_W-1];
    w_p_mag     = w_p_neg ? ACC_W'(-r_acc) : ACC_W'(r_acc);
    w_div_start = (r_state == S_DIV) && (r_cnt == 6'd0);
  end

  seq_restoring_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (w_p_mag),
    .divisor  (r_norm),
    .quotient (w_quot),
    .done     (w_div_done)
  );

  // Saturation: negative side reaches -32768, positive side only 32767.
  always_comb begin
    if (w_p_neg) begin
      w_sat_ovf = (w_quot > ACC_W'(32768));
      w_sat_val = w_sat_ovf ? 16'sh8000 : $signed(~w_quot[IN_W-1:0] + 16'd1);
    end else begin
      w_sat_ovf = (w_quot > ACC_W'(32767));
      w_sat_val = w_sat_ovf ? 16'sh7fff : $signed(w_quot[IN_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_norm  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_q[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a[0] <= a0;  r_a[1] <= a1;  r_a[2] <= a2;  r_a[3] <= a3;
            r_q[0] <= q0;  r_q[1] <= q1;  r_q[2] <= q2;  r_q[3] <= q3;
            r_norm  <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_norm <= w_norm_nxt;
          if (r_cnt == 6'd3) begin
            r_cnt <= '0;
            if (w_norm_nxt == '0) begin
              for (int i = 0; i < 4; i++) r_b[i] <= '0;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_state <= S_MAC;
            end
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nxt;
          if (r_cnt == 6'd3) begin
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DIV: begin
          if (r_cnt == 6'(DIV_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_WRITE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_WRITE: begin
          if (w_div_done) begin
            r_b[r_k] <= w_sat_val;
            if (w_sat_ovf) r_ovf <= 1'b1;
            if (r_k == 2'd3) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_k     <= r_k + 2'd1;
              r_cnt   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign b0          = r_b[0];
  assign b1          = r_b[1];
  assign b2          = r_b[2];
  assign b3          = r_b[3];
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_quaternion_division_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_quaternion_division_seq                                      |
// | Purpose  : Self-checking bench: directed vector table, random operations   |
// |            against an arithmetic reference model, and multi-cycle corner   |
// |            sequences (ignored re-start, mid-run reset, start held in FIN). |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_quaternion_division_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [15:0] a0, a1, a2, a3;
  logic signed [31:0] q0, q1, q2, q3;
  logic signed [15:0] b0, b1, b2, b3;
  logic               busy, done, div_by_zero, ovf;

  always #5 clk = ~clk;

  quaternion_division_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .ovf(ovf)
  );

  typedef struct {
    longint a[4];
    longint q[4];
    longint b[4];
    bit     ovf;
    bit     dbz;
    int     lat;
  } vec_t;

  vec_t   tbl[5];
  int     n_pass  = 0;
  int     n_total = 0;
  longint m_a[4], m_q[4], e_b[4];
  bit     e_ovf, e_dbz;
  int     e_lat;
  int     lat;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: b = conj(a) (x) q / |a|^2, truncating, saturated to s16.
  task automatic compute_expected();
    longint n, p[4], d;
    n = m_a[0]*m_a[0] + m_a[1]*m_a[1] + m_a[2]*m_a[2] + m_a[3]*m_a[3];
    e_ovf = 1'b0;
    if (n == 0) begin
      e_dbz = 1'b1;
      e_lat = 4;
      for (int i = 0; i < 4; i++) e_b[i] = 0;
    end else begin
      e_dbz = 1'b0;
      e_lat = 224;
      p[0] = m_a[0]*m_q[0] + m_a[1]*m_q[1] + m_a[2]*m_q[2] + m_a[3]*m_q[3];
      p[1] = m_a[0]*m_q[1] - m_a[1]*m_q[0] - m_a[2]*m_q[3] + m_a[3]*m_q[2];
      p[2] = m_a[0]*m_q[2] + m_a[1]*m_q[3] - m_a[2]*m_q[0] - m_a[3]*m_q[1];
      p[3] = m_a[0]*m_q[3] - m_a[1]*m_q[2] + m_a[2]*m_q[1] - m_a[3]*m_q[0];
      for (int i = 0; i < 4; i++) begin
        d = p[i] / n;
        if (d > 32767)       begin d = 32767;  e_ovf = 1'b1; end
        else if (d < -32768) begin d = -32768; e_ovf = 1'b1; end
        e_b[i] = d;
      end
    end
  endtask

  task automatic drive_inputs();
    a0 = 16'(m_a[0]); a1 = 16'(m_a[1]); a2 = 16'(m_a[2]); a3 = 16'(m_a[3]);
    q0 = 32'(m_q[0]); q1 = 32'(m_q[1]); q2 = 32'(m_q[2]); q3 = 32'(m_q[3]);
  endtask

  task automatic scramble_inputs();
    a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom); a3 = 16'($urandom);
    q0 = $urandom; q1 = $urandom; q2 = $urandom; q3 = $urandom;
  endtask

  // Drive operands, take the accepting edge, then make inputs garbage.
  task automatic launch(input string tag);
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_accept"}, longint'(busy), 1);
    scramble_inputs();
  endtask

  // Counts edges after the accept until done; start pulses on edge pulse_at+1.
  task automatic wait_done(input int pulse_at);
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == pulse_at);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_busy_at_done"}, longint'(busy), 0);
    check({tag, "_b0"}, longint'(b0), e_b[0]);
    check({tag, "_b1"}, longint'(b1), e_b[1]);
    check({tag, "_b2"}, longint'(b2), e_b[2]);
    check({tag, "_b3"}, longint'(b3), e_b[3]);
    check({tag, "_ovf"}, longint'(ovf), longint'(e_ovf));
    check({tag, "_dbz"}, longint'(div_by_zero), longint'(e_dbz));
  endtask

  task automatic run_op(input string tag, input int pulse_at);
    launch(tag);
    wait_done(pulse_at);
    check_result(tag);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, longint'(done), 0);
    check({tag, "_b0_held"}, longint'(b0), e_b[0]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_b0"}, longint'(b0), 0);
    check({tag, "_b1"}, longint'(b1), 0);
    check({tag, "_b2"}, longint'(b2), 0);
    check({tag, "_b3"}, longint'(b3), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_dbz"}, longint'(div_by_zero), 0);
    check({tag, "_ovf"}, longint'(ovf), 0);
  endtask

  initial begin
    tbl[0].a = '{1, 0, 0, 0}; tbl[0].q = '{100, -200, 300, -400};
    tbl[0].b = '{100, -200, 300, -400}; tbl[0].ovf = 0; tbl[0].dbz = 0; tbl[0].lat = 224;
    tbl[1].a = '{1, 2, 3, 4};  tbl[1].q = '{-60, 12, 30, 24};
    tbl[1].b = '{5, 6, 7, 8};  tbl[1].ovf = 0; tbl[1].dbz = 0; tbl[1].lat = 224;
    tbl[2].a = '{0, 0, 0, 0};  tbl[2].q = '{123, -456, 789, 1000};
    tbl[2].b = '{0, 0, 0, 0};  tbl[2].ovf = 0; tbl[2].dbz = 1; tbl[2].lat = 4;
    tbl[3].a = '{2, 0, 0, 0};  tbl[3].q = '{-7, 7, 1, -1};
    tbl[3].b = '{-3, 3, 0, 0}; tbl[3].ovf = 0; tbl[3].dbz = 0; tbl[3].lat = 224;
    tbl[4].a = '{1, 0, 0, 0};  tbl[4].q = '{40000, -40000, 0, 0};
    tbl[4].b = '{32767, -32768, 0, 0}; tbl[4].ovf = 1; tbl[4].dbz = 0; tbl[4].lat = 224;

    rst_n = 1'b0;
    start = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 4; c++) begin
        m_a[c] = tbl[i].a[c];
        m_q[c] = tbl[i].q[c];
        e_b[c] = tbl[i].b[c];
      end
      e_ovf = tbl[i].ovf;
      e_dbz = tbl[i].dbz;
      e_lat = tbl[i].lat;
      run_op($sformatf("vec%0d", i), -1);
    end

    // Random operations against the model; some with tiny a to force saturation
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r % 3 == 2) m_a[c] = longint'($urandom_range(0, 6)) - 3;
        else            m_a[c] = longint'($signed(16'($urandom)));
        m_q[c] = longint'($signed(32'($urandom)));
      end
      compute_expected();
      run_op($sformatf("rnd%0d", r), -1);
    end

    // Start re-pulsed mid-operation (with garbage inputs) must be ignored
    m_a = '{1, 2, 3, 4}; m_q = '{-60, 12, 30, 24};
    compute_expected();
    run_op("repulse", 100);

    // Reset mid-operation clears everything and does not restart
    m_a = '{3, -1, 2, 5}; m_q = '{1000000, -2000000, 3000000, 77};
    compute_expected();
    launch("rst_pre");
    repeat (150) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_idle_busy", longint'(busy), 0);
    run_op("post_reset", -1);

    // Start held high through FIN: accepted on the first IDLE edge
    m_a = '{2, 0, 0, 0}; m_q = '{-7, 7, 1, -1};
    compute_expected();
    launch("hold1");
    wait_done(-1);
    check_result("hold1");
    m_a = '{1, 0, 0, 0}; m_q = '{100, -200, 300, -400};
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    check("hold_fin_not_accepted", longint'(busy), 0);
    check("hold_fin_done_drop", longint'(done), 0);
    @(posedge clk); #1;
    check("hold_idle_accepted", longint'(busy), 1);
    start = 1'b0;
    scramble_inputs();
    compute_expected();
    wait_done(-1);
    check_result("hold2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
